// File: rtl/trigger_if.sv
// Signal bundle between the monitored-bus/config driver and trigger_unit.
// Build option TRIGGER_EDGE_EN adds the per-bit edge-select vector i_edge.
interface trigger_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]  i_data;
    logic [DATA_WIDTH-1:0]  i_value;
    logic [DATA_WIDTH-1:0]  i_mask;
    logic [COUNT_WIDTH-1:0] i_count;
    logic                   i_arm;
    logic                   i_clear;
`ifdef TRIGGER_EDGE_EN
    logic [DATA_WIDTH-1:0]  i_edge;
`endif
    logic                   o_trigger;
    logic                   o_armed;
    logic [COUNT_WIDTH-1:0] o_match_count;

`ifdef TRIGGER_EDGE_EN
    modport master (
        output i_data, i_value, i_mask, i_count, i_arm, i_clear, i_edge,
        input  o_trigger, o_armed, o_match_count
    );
    modport slave (
        input  i_data, i_value, i_mask, i_count, i_arm, i_clear, i_edge,
        output o_trigger, o_armed, o_match_count
    );
`else
    modport master (
        output i_data, i_value, i_mask, i_count, i_arm, i_clear,
        input  o_trigger, o_armed, o_match_count
    );
    modport slave (
        input  i_data, i_value, i_mask, i_count, i_arm, i_clear,
        output o_trigger, o_armed, o_match_count
    );
`endif
endinterface

// File: rtl/trigger_unit.sv
// Masked-match occurrence counter driving the logic analyzer trigger; no backpressure, 3-cycle i_data->o_trigger latency.
// Build option TRIGGER_EDGE_EN adds per-bit transition qualification selected by i_edge.
module trigger_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    trigger_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [DATA_WIDTH-1:0]  value_s;
    logic [DATA_WIDTH-1:0]  mask_s;
    logic [COUNT_WIDTH-1:0] count_s;
    logic [DATA_WIDTH-1:0]  d_q;
    logic                   match_d;
    logic                   match_q;
    logic [COUNT_WIDTH-1:0] match_cnt_q;
    logic [COUNT_WIDTH-1:0] match_cnt_inc;
    logic                   count_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_s <= '0;
            mask_s  <= '0;
            count_s <= COUNT_WIDTH'(1);
        end else if (bus.i_arm) begin
            value_s <= bus.i_value;
            mask_s  <= bus.i_mask;
            count_s <= (bus.i_count == '0) ? COUNT_WIDTH'(1) : bus.i_count;
        end
    end

`ifdef TRIGGER_EDGE_EN
    logic [DATA_WIDTH-1:0] edge_s;
    logic [DATA_WIDTH-1:0] d_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_s <= '0;
            d_prev <= '0;
        end else begin
            d_prev <= d_q;
            if (bus.i_arm) begin
                edge_s <= bus.i_edge;
            end
        end
    end

    // Edge bits additionally fail when the previous sample already held the value.
    assign match_d = ~|(((d_q ^ value_s) & mask_s) |
                        (edge_s & mask_s & ~(d_prev ^ value_s)));
`else
    assign match_d = ~|((d_q ^ value_s) & mask_s);
`endif

    // A compare registered on the arm cycle used the outgoing config; drop it so it never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q     <= '0;
            match_q <= 1'b0;
        end else begin
            d_q     <= bus.i_data;
            match_q <= match_d & ~bus.i_arm;
        end
    end

    assign match_cnt_inc = match_cnt_q + COUNT_WIDTH'(1);
    assign count_hit     = (state_q == ARMED) && match_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt_q <= '0;
        end else if (bus.i_clear || bus.i_arm) begin
            match_cnt_q <= '0;
        end else if (count_hit) begin
            match_cnt_q <= match_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.i_clear) begin
            state_d = IDLE;
        end else if (bus.i_arm) begin
            state_d = ARMED;
        end else if (count_hit && (match_cnt_inc == count_s)) begin
            state_d = FIRED;
        end
    end

    always_comb begin
        bus.o_trigger = 1'b0;
        bus.o_armed   = 1'b0;
        case (state_q)
            ARMED:   bus.o_armed   = 1'b1;
            FIRED:   bus.o_trigger = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_match_count = match_cnt_q;
endmodule
